vscale_imm_gen_pipe: RTL and testbench
======================================

Name: vscale_imm_gen_pipe

Overview:
Registered, back-pressured immediate generator for the vscale decode path. It accepts (instruction, imm_type, tag) tuples on a valid/ready interface and extracts the immediate. Results queue in a parametrised FIFO and are presented on an output valid/ready interface. Compared with the combinational generator it adds XLEN 32/64 sign extension, B-type and CSR zimm forms, an illegal-type flag, flush, and occupancy reporting.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64; immediate is sign/zero-extended to XLEN.
DEPTH, 2, FIFO entries; power of two, >= 2.
TAG_W, 5, width of the opaque sideband tag carried with each entry (e.g. rd/ROB id).

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  asynchronous active-low reset
flush  input  1  synchronous discard of all queued entries
in_valid  input  1  input tuple valid
in_ready  output  1  block can accept the tuple this cycle
in_inst  input  32  raw instruction word
in_imm_type  input  3  immediate format select
in_tag  input  TAG_W  sideband tag
out_valid  output  1  head entry valid
out_ready  input  1  consumer accepts head this cycle
out_imm  output  XLEN  extracted immediate
out_tag  output  TAG_W  tag of head entry
out_illegal  output  1  head entry had an unsupported imm_type
count  output  $clog2(DEPTH+1)  current occupancy

Behaviour:
- Reset (reset_n low, asynchronous): count=0, out_valid=0, pointers=0; out_imm/out_tag/out_illegal=0. in_ready=1 immediately after release.
- Immediate formats (inst bit 31 = sign bit s; all sign extension is to XLEN):
  - I=3'd0: sext(inst[31:20]).
  - S=3'd1: sext({inst[31:25],inst[11:7]}).
  - B=3'd2: sext({inst[31],inst[7],inst[30:25],inst[11:8],1'b0}).
  - U=3'd3: sext({inst[31:12],12'b0}).
  - J=3'd4: sext({inst[31],inst[19:12],inst[20],inst[30:21],1'b0}).
  - Z=3'd5: zero-extend inst[19:15].
  - 3'd6/3'd7: I-form value, illegal=1. All other types give illegal=0.
- Extraction is combinational on the input side. The result is written into the FIFO on push. Input-to-output latency is exactly 1 cycle when the FIFO is empty.
- Push occurs when in_valid && in_ready. Pop occurs when out_valid && out_ready.
- in_ready = (count < DEPTH) || out_ready. This combinational path from out_ready is intentional. When full, a simultaneous push and pop is allowed and count is unchanged.
- out_valid = (count != 0). Head data is stable while out_valid && !out_ready.
- When out_valid=0, out_imm, out_tag and out_illegal are driven to 0.
- Simultaneous push and pop when empty: not a bypass. The pushed entry appears on the following cycle.
- Pointers wrap modulo DEPTH. count never exceeds DEPTH or underflows. Inputs presented while in_ready=0 are ignored and must be held by the producer.
- flush (synchronous): next state is count=0 and pointers=0. A push or pop in the same cycle is discarded. in_ready is 0 while flush=1.
- Reset asserted mid-operation: all entries are lost immediately. There is no partial output.

Decomposition:
- Shared header vscale_ctrl_constants.vh gains IMM_B and IMM_Z, renumbers to the encodings above, adds IMM_TYPE_WIDTH=3, and extends the XLEN define.
- Natural sub-module: vscale_imm_extract, the combinational (inst, imm_type) -> (imm, illegal) function, parametrised by XLEN.
- FIFO storage and control stay inline in vscale_imm_gen_pipe.

Test Plan:
- Format check, XLEN=32, one push per cycle, out_ready=1. Required out_imm one cycle after each push:
  - I 0xFFF00093 -> 0xFFFFFFFF.
  - S 0xFE20AE23 -> 0xFFFFFFFC.
  - B 0xFE000FE3 -> 0xFFFFFFFE.
  - U 0x123450B7 -> 0x12345000.
  - Z 0x340FD073 -> 0x0000001F.
- XLEN=64: U 0x800000B7 -> 0xFFFFFFFF80000000; J 0x0000006F -> 0x0. imm_type=3'd7 with 0x7FF00013 -> imm 0x7FF, out_illegal=1.
- DEPTH=2, out_ready=0, push tags 1,2,3 on consecutive cycles:
  - count reaches 2, in_ready=0, tag 3 is held by the producer.
  - Then raise out_ready for one cycle with tag 3 still valid: tag 1 pops, tag 3 pushes, count stays 2.
  - Output order is 1,2,3.
- Fill to 2 entries, assert flush together with in_valid=1: next cycle count=0, out_valid=0, the flushed-cycle input is never output, in_ready=1.
- Assert reset_n=0 asynchronously mid-cycle with 2 entries queued: out_valid and count drop to 0 before the next edge. After release, the first pushed entry emerges with a correct imm and tag.
- Random stream of 1000 tuples with random in_valid/out_ready: compare against a reference model in order, check count never exceeds DEPTH, and check no entry is lost or duplicated.

Source files
------------

// File: rtl/vscale_imm_gen_pipe_pkg.sv
// Shared definitions for the vscale registered immediate generator.
// - IMM_TYPE_WIDTH: width of the immediate format select.
// - imm_type_e: immediate format encodings. Codes 6 and 7 are reserved.
// - imm_type_is_illegal(): flags the reserved encodings.
package vscale_imm_gen_pipe_pkg;

  localparam int IMM_TYPE_WIDTH = 3;

  typedef enum logic [IMM_TYPE_WIDTH-1:0] {
    IMM_I    = 3'd0,
    IMM_S    = 3'd1,
    IMM_B    = 3'd2,
    IMM_U    = 3'd3,
    IMM_J    = 3'd4,
    IMM_Z    = 3'd5,
    IMM_RSV6 = 3'd6,
    IMM_RSV7 = 3'd7
  } imm_type_e;

  function automatic logic imm_type_is_illegal(input logic [IMM_TYPE_WIDTH-1:0] imm_type);
    return (imm_type == IMM_RSV6) || (imm_type == IMM_RSV7);
  endfunction

endpackage

// File: rtl/vscale_imm_extract.sv
// Combinational immediate extractor: (inst, imm_type) -> (imm, illegal).
// Ports:
//   inst      [31:0]            raw instruction word
//   imm_type  [2:0]             immediate format select
//   imm       [XLEN-1:0]        extracted immediate, sign/zero-extended to XLEN
//   illegal                     imm_type is a reserved code (imm then holds the I-form)
module vscale_imm_extract
  import vscale_imm_gen_pipe_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]               inst,
  input  logic [IMM_TYPE_WIDTH-1:0] imm_type,
  output logic [XLEN-1:0]           imm,
  output logic                      illegal
);

  // The opcode field never contributes to any immediate.
  logic [6:0]  unused_opcode;
  logic [31:0] imm32_s;

  assign unused_opcode = inst[6:0];

  // Build every format as a 32-bit value whose bit 31 is the extension bit.
  // The Z form has a zero top bit, so one signed widening serves all formats.
  always_comb begin
    imm32_s = 32'd0;
    illegal = imm_type_is_illegal(imm_type);
    case (imm_type_e'(imm_type))
      IMM_I:   imm32_s = {{20{inst[31]}}, inst[31:20]};
      IMM_S:   imm32_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      IMM_B:   imm32_s = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      IMM_U:   imm32_s = {inst[31:12], 12'd0};
      IMM_J:   imm32_s = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      IMM_Z:   imm32_s = {27'd0, inst[19:15]};
      default: imm32_s = {{20{inst[31]}}, inst[31:20]};
    endcase
  end

  assign imm = XLEN'($signed(imm32_s));

endmodule

// File: rtl/vscale_imm_gen_pipe.sv
// Registered, back-pressured immediate generator with an output FIFO.
// Ports:
//   clk, reset_n      rising-edge clock, asynchronous active-low reset
//   flush             synchronous discard of every queued entry
//   in_valid/in_ready input handshake; in_inst, in_imm_type, in_tag are the tuple
//   out_valid/out_ready output handshake; out_imm, out_tag, out_illegal describe the head
//   count             current FIFO occupancy
module vscale_imm_gen_pipe
  import vscale_imm_gen_pipe_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2,
  parameter int TAG_W = 5
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [31:0]                  in_inst,
  input  logic [IMM_TYPE_WIDTH-1:0]    in_imm_type,
  input  logic [TAG_W-1:0]             in_tag,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [XLEN-1:0]              out_imm,
  output logic [TAG_W-1:0]             out_tag,
  output logic                         out_illegal,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [XLEN-1:0]  ext_imm_s;
  logic             ext_illegal_s;
  logic             push_s;
  logic             pop_s;

  logic [XLEN-1:0]  imm_mem_q [DEPTH];
  logic [XLEN-1:0]  imm_mem_d [DEPTH];
  logic [TAG_W-1:0] tag_mem_q [DEPTH];
  logic [TAG_W-1:0] tag_mem_d [DEPTH];
  logic             ill_mem_q [DEPTH];
  logic             ill_mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  vscale_imm_extract #(
    .XLEN (XLEN)
  ) u_extract (
    .inst     (in_inst),
    .imm_type (in_imm_type),
    .imm      (ext_imm_s),
    .illegal  (ext_illegal_s)
  );

  // A full FIFO still accepts when the head leaves this cycle (combinational
  // out_ready path); nothing is accepted during a flush.
  assign in_ready = !flush && ((count_q < CNT_W'(DEPTH)) || out_ready);
  assign push_s   = in_valid && in_ready;
  assign pop_s    = out_valid && out_ready && !flush;

  // Next-state for storage, pointers and occupancy; flush overrides push/pop.
  always_comb begin
    imm_mem_d = imm_mem_q;
    tag_mem_d = tag_mem_q;
    ill_mem_d = ill_mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    if (flush) begin
      wr_ptr_d = {PTR_W{1'b0}};
      rd_ptr_d = {PTR_W{1'b0}};
      count_d  = {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        // When full, wr_ptr equals rd_ptr; the head is read from the
        // current-cycle registers, so overwriting its slot here is safe.
        imm_mem_d[wr_ptr_q] = ext_imm_s;
        tag_mem_d[wr_ptr_q] = in_tag;
        ill_mem_d[wr_ptr_q] = ext_illegal_s;
        wr_ptr_d            = wr_ptr_q + PTR_W'(1'b1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1'b1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CNT_W'(1'b1);
        2'b01:   count_d = count_q - CNT_W'(1'b1);
        default: count_d = count_q;
      endcase
    end
  end

  // State registers; reset clears storage as well as control.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        imm_mem_q[i] <= {XLEN{1'b0}};
        tag_mem_q[i] <= {TAG_W{1'b0}};
        ill_mem_q[i] <= 1'b0;
      end
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
    end else begin
      imm_mem_q <= imm_mem_d;
      tag_mem_q <= tag_mem_d;
      ill_mem_q <= ill_mem_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
    end
  end

  // Head presentation; the data outputs read as zero while the FIFO is empty.
  always_comb begin
    out_valid = (count_q != {CNT_W{1'b0}});
    if (out_valid) begin
      out_imm     = imm_mem_q[rd_ptr_q];
      out_tag     = tag_mem_q[rd_ptr_q];
      out_illegal = ill_mem_q[rd_ptr_q];
    end else begin
      out_imm     = {XLEN{1'b0}};
      out_tag     = {TAG_W{1'b0}};
      out_illegal = 1'b0;
    end
  end

  assign count = count_q;

endmodule

// File: tb/tb_vscale_imm_gen_pipe.sv
module tb_vscale_imm_gen_pipe;

  localparam int DEPTH = 2;
  localparam int TAG_W = 5;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_inst;
  logic [2:0]  in_imm_type;
  logic [TAG_W-1:0] in_tag;
  logic        out_ready;

  logic        in_ready32, out_valid32, out_illegal32;
  logic [31:0] out_imm32;
  logic [TAG_W-1:0] out_tag32;
  logic [1:0]  count32;

  logic        in_ready64, out_valid64, out_illegal64;
  logic [63:0] out_imm64;
  logic [TAG_W-1:0] out_tag64;
  logic [1:0]  count64;

  int n_checks = 0;
  int n_errors = 0;
  int n_push = 0;
  int n_pop = 0;
  bit last_push;

  typedef struct {
    logic [63:0]      imm;
    logic [TAG_W-1:0] tag;
    logic             ill;
  } ent_t;

  ent_t mq[$];

  typedef struct {
    logic [31:0] inst;
    logic [2:0]  typ;
    logic [63:0] exp_imm;
    logic        exp_ill;
  } vec_t;

  always #5 clk = ~clk;

  vscale_imm_gen_pipe #(.XLEN(32), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut32 (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready32), .in_inst(in_inst),
    .in_imm_type(in_imm_type), .in_tag(in_tag),
    .out_valid(out_valid32), .out_ready(out_ready), .out_imm(out_imm32),
    .out_tag(out_tag32), .out_illegal(out_illegal32), .count(count32)
  );

  vscale_imm_gen_pipe #(.XLEN(64), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut64 (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready64), .in_inst(in_inst),
    .in_imm_type(in_imm_type), .in_tag(in_tag),
    .out_valid(out_valid64), .out_ready(out_ready), .out_imm(out_imm64),
    .out_tag(out_tag64), .out_illegal(out_illegal64), .count(count64)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Immediate value as a signed integer, built from the format's bit fields.
  function automatic logic [63:0] ref_imm(input logic [31:0] inst, input logic [2:0] t);
    longint raw;
    int     bits;
    case (t)
      3'd1: begin raw = longint'({inst[31:25], inst[11:7]}); bits = 12; end
      3'd2: begin raw = longint'({inst[31], inst[7], inst[30:25], inst[11:8]}) * 2; bits = 13; end
      3'd3: begin raw = longint'(inst[31:12]) * 4096; bits = 32; end
      3'd4: begin raw = longint'({inst[31], inst[19:12], inst[20], inst[30:21]}) * 2; bits = 21; end
      3'd5: begin raw = longint'(inst[19:15]); bits = 0; end
      default: begin raw = longint'(inst[31:20]); bits = 12; end
    endcase
    if (bits != 0 && raw >= (longint'(1) << (bits - 1)))
      raw = raw - (longint'(1) << bits);
    return raw;
  endfunction

  task automatic check_state();
    logic [63:0] e_imm;
    logic [TAG_W-1:0] e_tag;
    logic e_ill, e_val, e_rdy;
    e_val = (mq.size() != 0);
    e_imm = e_val ? mq[0].imm : 64'd0;
    e_tag = e_val ? mq[0].tag : '0;
    e_ill = e_val ? mq[0].ill : 1'b0;
    e_rdy = !flush && (mq.size() < DEPTH || out_ready);
    chk("count32", count32, mq.size());
    chk("count64", count64, mq.size());
    chk("out_valid32", out_valid32, e_val);
    chk("out_valid64", out_valid64, e_val);
    chk("in_ready32", in_ready32, e_rdy);
    chk("in_ready64", in_ready64, e_rdy);
    chk("out_imm32", out_imm32, e_imm[31:0]);
    chk("out_imm64", out_imm64, e_imm);
    chk("out_tag32", out_tag32, e_tag);
    chk("out_tag64", out_tag64, e_tag);
    chk("out_illegal32", out_illegal32, e_ill);
    chk("out_illegal64", out_illegal64, e_ill);
    chk("count_bound", (count32 <= 2'(DEPTH)) ? 64'd1 : 64'd0, 64'd1);
  endtask

  // One clock: check outputs against the model, then advance the model.
  task automatic do_cycle();
    bit m_push, m_pop;
    ent_t e;
    #1;
    check_state();
    m_push = in_valid && !flush && (mq.size() < DEPTH || out_ready);
    m_pop  = (mq.size() != 0) && out_ready && !flush;
    e.imm = ref_imm(in_inst, in_imm_type);
    e.tag = in_tag;
    e.ill = (in_imm_type >= 3'd6);
    @(posedge clk);
    last_push = 1'b0;
    if (flush) begin
      mq.delete();
    end else begin
      if (m_pop) begin
        void'(mq.pop_front());
        n_pop++;
      end
      if (m_push) begin
        mq.push_back(e);
        n_push++;
        last_push = 1'b1;
      end
    end
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] inst, input logic [2:0] t,
                       input logic [TAG_W-1:0] tag);
    in_valid = v;
    in_inst = inst;
    in_imm_type = t;
    in_tag = tag;
  endtask

  vec_t vecs[8];
  bit have_tuple;
  int cyc;

  initial begin
    vecs[0] = '{32'hFFF00093, 3'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
    vecs[1] = '{32'hFE20AE23, 3'd1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0};
    vecs[2] = '{32'hFE000FE3, 3'd2, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0};
    vecs[3] = '{32'h123450B7, 3'd3, 64'h0000_0000_1234_5000, 1'b0};
    vecs[4] = '{32'h340FD073, 3'd5, 64'h0000_0000_0000_001F, 1'b0};
    vecs[5] = '{32'h800000B7, 3'd3, 64'hFFFF_FFFF_8000_0000, 1'b0};
    vecs[6] = '{32'h0000006F, 3'd4, 64'h0000_0000_0000_0000, 1'b0};
    vecs[7] = '{32'h7FF00013, 3'd7, 64'h0000_0000_0000_07FF, 1'b1};

    reset_n = 1'b0;
    flush = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, 32'd0, 3'd0, '0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    // Reset state.
    #1;
    chk("rst_count", count32, 64'd0);
    chk("rst_out_valid", out_valid32, 64'd0);
    chk("rst_out_imm", out_imm64, 64'd0);
    chk("rst_in_ready", in_ready32, 64'd1);
    do_cycle();

    // Format table: one push per cycle, head checked the following cycle.
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, vecs[i].inst, vecs[i].typ, TAG_W'(i));
      do_cycle();
      #1;
      chk($sformatf("vec%0d_imm64", i), out_imm64, vecs[i].exp_imm);
      chk($sformatf("vec%0d_imm32", i), out_imm32, {32'd0, vecs[i].exp_imm[31:0]});
      chk($sformatf("vec%0d_ill", i), out_illegal64, vecs[i].exp_ill);
      chk($sformatf("vec%0d_tag", i), out_tag32, i);
    end
    drive(1'b0, 32'd0, 3'd0, '0);
    do_cycle();

    // Back-pressure: tags 1,2,3 with out_ready low, then a full-FIFO push+pop.
    out_ready = 1'b0;
    drive(1'b1, 32'h00100093, 3'd0, 5'd1);
    do_cycle();
    drive(1'b1, 32'h00200093, 3'd0, 5'd2);
    do_cycle();
    drive(1'b1, 32'h00300093, 3'd0, 5'd3);
    #1;
    chk("bp_full_count", count32, 64'd2);
    chk("bp_full_in_ready", in_ready32, 64'd0);
    do_cycle();
    out_ready = 1'b1;
    #1;
    chk("bp_swap_in_ready", in_ready32, 64'd1);
    chk("bp_head_tag1", out_tag32, 64'd1);
    do_cycle();
    drive(1'b0, 32'd0, 3'd0, '0);
    #1;
    chk("bp_swap_count", count32, 64'd2);
    chk("bp_head_tag2", out_tag32, 64'd2);
    do_cycle();
    #1;
    chk("bp_head_tag3", out_tag32, 64'd3);
    chk("bp_head3_imm", out_imm32, 64'd3);
    do_cycle();
    do_cycle();

    // Flush with a simultaneous input: the flushed-cycle tuple never appears.
    out_ready = 1'b0;
    drive(1'b1, 32'h00A00093, 3'd0, 5'd10);
    do_cycle();
    drive(1'b1, 32'h00B00093, 3'd0, 5'd11);
    do_cycle();
    flush = 1'b1;
    drive(1'b1, 32'h00900093, 3'd0, 5'd9);
    #1;
    chk("flush_in_ready", in_ready32, 64'd0);
    do_cycle();
    flush = 1'b0;
    drive(1'b0, 32'd0, 3'd0, '0);
    #1;
    chk("flush_count", count32, 64'd0);
    chk("flush_out_valid", out_valid32, 64'd0);
    chk("flush_in_ready_after", in_ready32, 64'd1);
    out_ready = 1'b1;
    do_cycle();
    do_cycle();

    // Asynchronous reset with two entries queued.
    out_ready = 1'b0;
    drive(1'b1, 32'hFFF00093, 3'd0, 5'd4);
    do_cycle();
    drive(1'b1, 32'hFFE00093, 3'd0, 5'd5);
    do_cycle();
    drive(1'b0, 32'd0, 3'd0, '0);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_out_valid", out_valid32, 64'd0);
    chk("arst_count", count64, 64'd0);
    mq.delete();
    @(posedge clk);
    #1 reset_n = 1'b1;
    drive(1'b1, 32'h8000_0037, 3'd3, 5'd17);
    do_cycle();
    drive(1'b0, 32'd0, 3'd0, '0);
    #1;
    chk("arst_first_imm64", out_imm64, 64'hFFFF_FFFF_8000_0000);
    chk("arst_first_tag", out_tag64, 64'd17);
    out_ready = 1'b1;
    do_cycle();
    do_cycle();

    // Random stream of 1000 tuples; producer holds a tuple until accepted.
    n_push = 0;
    n_pop = 0;
    have_tuple = 1'b0;
    cyc = 0;
    while (n_push < 1000 && cyc < 20000) begin
      if (!have_tuple) begin
        in_inst = $urandom;
        in_imm_type = 3'($urandom_range(0, 7));
        in_tag = TAG_W'($urandom);
        have_tuple = 1'b1;
      end
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      do_cycle();
      if (last_push) have_tuple = 1'b0;
      cyc++;
    end
    chk("rand_budget", (cyc < 20000) ? 64'd1 : 64'd0, 64'd1);
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) do_cycle();
    chk("rand_pushed", n_push, 64'd1000);
    chk("rand_popped", n_pop, 64'd1000);
    chk("rand_drained", count32, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
